// File: rtl/wordle_scorer_if.sv
// Handshake and result bundle between the game controller and the scorer.
// The controller drives guess/answer plus start/new_game pulses; the scorer
// returns per-letter colours, the guess count and the win/lose flags.
interface wordle_scorer_if #(
  parameter int WORD_LEN    = 5,
  parameter int LETTER_W    = 8,
  parameter int MAX_GUESSES = 6,
  parameter int GC_W        = $clog2(MAX_GUESSES + 1)
);
  logic                         start;
  logic                         new_game;
  logic [WORD_LEN*LETTER_W-1:0] guess;
  logic [WORD_LEN*LETTER_W-1:0] answer;
  logic                         busy;
  logic                         done;
  logic [2*WORD_LEN-1:0]        colors;
  logic [GC_W-1:0]              guess_count;
  logic                         win;
  logic                         lose;

  modport master (
    output start, new_game, guess, answer,
    input  busy, done, colors, guess_count, win, lose
  );

  modport slave (
    input  start, new_game, guess, answer,
    output busy, done, colors, guess_count, win, lose
  );
endinterface

// File: rtl/wordle_scorer.sv
// Per-letter Wordle scoring engine with game bookkeeping.
// One pass marks exact matches, then one position per cycle looks for an
// unused answer letter to award a yellow, so duplicate letters are only
// credited as often as they occur in the answer. Results, guess count and
// sticky win/lose flags are all registered.
module wordle_scorer #(
  parameter int WORD_LEN    = 5,
  parameter int LETTER_W    = 8,
  parameter int MAX_GUESSES = 6,
  parameter int GC_W        = $clog2(MAX_GUESSES + 1)
) (
  input logic            Clk,
  input logic            reset,
  wordle_scorer_if.slave bus
);

  localparam int                IDX_W    = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [GC_W-1:0]   MAX_GC   = GC_W'(MAX_GUESSES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_FINISH
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [LETTER_W-1:0]   r_g [WORD_LEN];
  logic [LETTER_W-1:0]   r_a [WORD_LEN];
  logic [WORD_LEN-1:0]   r_green;
  logic [WORD_LEN-1:0]   r_used;
  logic [WORD_LEN-1:0]   r_yellow;
  logic [IDX_W-1:0]      r_idx;

  logic [2*WORD_LEN-1:0] r_colors;
  logic [GC_W-1:0]       r_count;
  logic                  r_win;
  logic                  r_lose;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic [WORD_LEN-1:0]   w_eq;
  logic [WORD_LEN-1:0]   w_take;
  logic                  w_found;
  logic [2*WORD_LEN-1:0] w_colors;
  logic                  w_all_green;
  logic [GC_W-1:0]       w_count_inc;

  // A request only counts while the game is live and no clear is pending.
  assign w_accept    = bus.start && !bus.new_game && !r_win && !r_lose;
  assign w_all_green = &r_green;
  assign w_count_inc = r_count + 1'b1;

  // State register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; new_game overrides every transition.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_GREEN;
      S_GREEN:  w_state_nxt = S_YELLOW;
      S_YELLOW: if (r_idx == LAST_IDX) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (bus.new_game) w_state_nxt = S_IDLE;
  end

  // Exact-position matches of the latched words.
  always_comb begin
    w_eq = '0;
    for (int i = 0; i < WORD_LEN; i++) w_eq[i] = (r_g[i] == r_a[i]);
  end

  // Lowest unused answer position holding the current guess letter.
  always_comb begin
    // NOTE: blocking assignments here are deliberate: w_found must be seen
    // updated by later loop iterations within the same evaluation.
    w_take  = '0;
    w_found = 1'b0;
    for (int j = 0; j < WORD_LEN; j++) begin
      if (!w_found && !r_used[j] && (r_a[j] == r_g[r_idx])) begin
        w_take[j] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  // Pack green/yellow flags into the colour code, position 0 in the MSBs.
  always_comb begin
    w_colors = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      w_colors[2*(WORD_LEN-1-i) +: 2] = {r_green[i], r_yellow[i]};
    end
  end

  // Capture the words on acceptance so input changes mid-operation are ignored.
  always_ff @(posedge Clk) begin
    // NOTE: these word registers carry no reset; they are always written
    // before being read, so resetting them would only add reset fan-out.
    if (r_state == S_IDLE && w_accept) begin
      for (int i = 0; i < WORD_LEN; i++) begin
        r_g[i] <= bus.guess[LETTER_W*(WORD_LEN-1-i) +: LETTER_W];
        r_a[i] <= bus.answer[LETTER_W*(WORD_LEN-1-i) +: LETTER_W];
      end
    end
  end

  // Scoring datapath and game bookkeeping.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_green  <= '0;
      r_used   <= '0;
      r_yellow <= '0;
      r_idx    <= '0;
      r_colors <= '0;
      r_count  <= '0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= 1'b0;
      if (bus.new_game) begin
        r_colors <= '0;
        r_count  <= '0;
        r_win    <= 1'b0;
        r_lose   <= 1'b0;
      end else begin
        case (r_state)
          S_GREEN: begin
            r_green  <= w_eq;
            r_used   <= w_eq;
            r_yellow <= '0;
            r_idx    <= '0;
          end
          S_YELLOW: begin
            if (!r_green[r_idx] && w_found) begin
              r_yellow[r_idx] <= 1'b1;
              r_used          <= r_used | w_take;
            end
            r_idx <= r_idx + 1'b1;
          end
          S_FINISH: begin
            r_colors <= w_colors;
            r_count  <= w_count_inc;
            r_done   <= 1'b1;
            if (w_all_green)                r_win  <= 1'b1;
            else if (w_count_inc == MAX_GC) r_lose <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.colors      = r_colors;
  assign bus.guess_count = r_count;
  assign bus.win         = r_win;
  assign bus.lose        = r_lose;

endmodule

// File: tb/tb_wordle_scorer.sv
// Self-checking bench for wordle_scorer: a default 5x8 instance and a 4x5
// instance, table vectors, hand-written protocol sequences and random games
// checked against a letter-counting reference model.
module tb_wordle_scorer;

  localparam int WL  = 5;
  localparam int LW  = 8;
  localparam int WL4 = 4;
  localparam int LW4 = 5;
  localparam int MG  = 6;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  wordle_scorer_if #(.WORD_LEN(WL),  .LETTER_W(LW),  .MAX_GUESSES(MG)) bus_a ();
  wordle_scorer_if #(.WORD_LEN(WL4), .LETTER_W(LW4), .MAX_GUESSES(MG)) bus_b ();

  wordle_scorer #(.WORD_LEN(WL), .LETTER_W(LW), .MAX_GUESSES(MG)) u_dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  wordle_scorer #(.WORD_LEN(WL4), .LETTER_W(LW4), .MAX_GUESSES(MG)) u_dut4 (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  int ma_count, mb_count;
  bit ma_win, ma_lose, mb_win, mb_lose;

  typedef struct {
    string      name;
    string      g;
    string      a;
    logic [9:0] exp;
  } vec_t;

  vec_t va [6];
  vec_t vb [3];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Encode an uppercase string: ASCII for 8-bit letters, A=1.. for narrower.
  function automatic logic [39:0] enc(input string s, input int lw);
    logic [39:0] w = '0;
    for (int i = 0; i < s.len(); i++) begin
      int c = s[i];
      if (lw != 8) c -= 64;
      w = (w << lw) | 40'(c);
    end
    return w;
  endfunction

  function automatic logic [39:0] rand_word(input int n, input int lw);
    logic [39:0] w = '0;
    int base = (lw == 8) ? 65 : 1;
    for (int i = 0; i < n; i++) w = (w << lw) | 40'(base + int'($urandom_range(0, 3)));
    return w;
  endfunction

  // Reference scoring: greens first, then yellows limited by how many of each
  // letter remain unmatched in the answer.
  function automatic logic [9:0] model_colors(input logic [39:0] g, input logic [39:0] a,
                                              input int n, input int lw);
    int ga [5];
    int aa [5];
    bit grn [5];
    int cnt [256];
    logic [9:0] c = '0;
    for (int k = 0; k < 256; k++) cnt[k] = 0;
    for (int i = 0; i < n; i++) begin
      ga[i] = int'((g >> ((n-1-i)*lw)) & ((40'd1 << lw) - 40'd1));
      aa[i] = int'((a >> ((n-1-i)*lw)) & ((40'd1 << lw) - 40'd1));
    end
    for (int i = 0; i < n; i++) begin
      grn[i] = (ga[i] == aa[i]);
      if (!grn[i]) cnt[aa[i]]++;
    end
    for (int i = 0; i < n; i++) begin
      if (grn[i]) c[2*(n-1-i)+1] = 1'b1;
      else if (cnt[ga[i]] > 0) begin
        c[2*(n-1-i)] = 1'b1;
        cnt[ga[i]]--;
      end
    end
    return c;
  endfunction

  // ---------------- default instance helpers ----------------
  task automatic new_game_a();
    bus_a.new_game = 1'b1;
    step();
    bus_a.new_game = 1'b0;
    ma_count = 0; ma_win = 0; ma_lose = 0;
  endtask

  task automatic run_a(input logic [39:0] g, input logic [39:0] a, output int lat, output int nb);
    bus_a.guess  = g;
    bus_a.answer = a;
    bus_a.start  = 1'b1;
    step();
    bus_a.start = 1'b0;
    lat = 0;
    nb  = 0;
    while (!bus_a.done && lat < 20) begin
      if (bus_a.busy) nb++;
      step();
      lat++;
    end
  endtask

  task automatic watch_a(input int n, output int nd, output int nb);
    nd = 0;
    nb = 0;
    repeat (n) begin
      step();
      if (bus_a.done) nd++;
      if (bus_a.busy) nb++;
    end
  endtask

  task automatic score_a(input string tag, input logic [39:0] g, input logic [39:0] a);
    int lat, nb;
    logic [9:0] exp_c;
    exp_c = model_colors(g, a, WL, LW);
    run_a(g, a, lat, nb);
    ma_count++;
    if (g == a) ma_win = 1;
    else if (ma_count == MG) ma_lose = 1;
    check({tag, " latency"},     40'(lat), 40'd7);
    check({tag, " busy_cycles"}, 40'(nb), 40'd7);
    check({tag, " busy@done"},   40'(bus_a.busy), 40'd0);
    check({tag, " colors"},      40'(bus_a.colors), 40'(exp_c));
    check({tag, " count"},       40'(bus_a.guess_count), 40'(ma_count));
    check({tag, " win"},         40'(bus_a.win), 40'(ma_win));
    check({tag, " lose"},        40'(bus_a.lose), 40'(ma_lose));
  endtask

  // ---------------- 4x5 instance helpers ----------------
  task automatic new_game_b();
    bus_b.new_game = 1'b1;
    step();
    bus_b.new_game = 1'b0;
    mb_count = 0; mb_win = 0; mb_lose = 0;
  endtask

  task automatic score_b(input string tag, input logic [39:0] g, input logic [39:0] a);
    int lat;
    logic [9:0] exp_c;
    exp_c = model_colors(g, a, WL4, LW4);
    bus_b.guess  = g[19:0];
    bus_b.answer = a[19:0];
    bus_b.start  = 1'b1;
    step();
    bus_b.start = 1'b0;
    lat = 0;
    while (!bus_b.done && lat < 20) begin
      step();
      lat++;
    end
    mb_count++;
    if (g == a) mb_win = 1;
    else if (mb_count == MG) mb_lose = 1;
    check({tag, " latency"}, 40'(lat), 40'd6);
    check({tag, " colors"},  40'(bus_b.colors), 40'(exp_c));
    check({tag, " count"},   40'(bus_b.guess_count), 40'(mb_count));
    check({tag, " win"},     40'(bus_b.win), 40'(mb_win));
    check({tag, " lose"},    40'(bus_b.lose), 40'(mb_lose));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nd, nb, lat;
    logic [39:0] ans, g;
    string miss [5];

    miss[0] = "ZZZZZ"; miss[1] = "EERIE"; miss[2] = "ABBEY";
    miss[3] = "NACRE"; miss[4] = "CRONE";

    va[0] = '{"exact",    "CRANE", "CRANE", 10'b1010101010};
    va[1] = '{"dup_green","EERIE", "CRANE", 10'b0000010010};
    va[2] = '{"crossed",  "BABES", "ABBEY", 10'b0101101000};
    va[3] = '{"all_grey", "ZZZZZ", "CRANE", 10'b0000000000};
    va[4] = '{"anagram",  "ECRAN", "CRANE", 10'b0101010101};
    va[5] = '{"dup_once", "SPEED", "ABIDE", 10'b0000010001};

    vb[0] = '{"b_exact",  "CRAN", "CRAN", 10'b0010101010};
    vb[1] = '{"b_crossed","BABE", "ABBE", 10'b0001011010};
    vb[2] = '{"b_dup",    "EEEE", "ERIE", 10'b0010000010};

    bus_a.start = 0; bus_a.new_game = 0; bus_a.guess = '0; bus_a.answer = '0;
    bus_b.start = 0; bus_b.new_game = 0; bus_b.guess = '0; bus_b.answer = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state.
    check("rst busy",   40'(bus_a.busy), 40'd0);
    check("rst done",   40'(bus_a.done), 40'd0);
    check("rst colors", 40'(bus_a.colors), 40'd0);
    check("rst count",  40'(bus_a.guess_count), 40'd0);
    check("rst win",    40'(bus_a.win), 40'd0);
    check("rst lose",   40'(bus_a.lose), 40'd0);
    check("rst b busy", 40'(bus_b.busy), 40'd0);
    ma_count = 0; ma_win = 0; ma_lose = 0;
    mb_count = 0; mb_win = 0; mb_lose = 0;

    // Table vectors, each in a fresh game.
    for (int i = 0; i < 6; i++) begin
      new_game_a();
      score_a(va[i].name, enc(va[i].g, LW), enc(va[i].a, LW));
      check({va[i].name, " table"}, 40'(bus_a.colors), 40'(va[i].exp));
    end

    // After a win further starts are ignored.
    new_game_a();
    score_a("win1", enc("CRANE", LW), enc("CRANE", LW));
    bus_a.start = 1'b1;
    watch_a(10, nd, nb);
    bus_a.start = 1'b0;
    check("after_win done", 40'(nd), 40'd0);
    check("after_win busy", 40'(nb), 40'd0);
    check("after_win count", 40'(bus_a.guess_count), 40'd1);

    // Loss over six back-to-back misses, then ignored start, then clear.
    new_game_a();
    for (int i = 0; i < MG; i++) score_a("loss", enc(miss[i % 5], LW), enc("CRANE", LW));
    bus_a.start = 1'b1;
    watch_a(10, nd, nb);
    bus_a.start = 1'b0;
    check("after_lose done",  40'(nd), 40'd0);
    check("after_lose busy",  40'(nb), 40'd0);
    check("after_lose count", 40'(bus_a.guess_count), 40'd6);
    new_game_a();
    check("ng colors", 40'(bus_a.colors), 40'd0);
    check("ng count",  40'(bus_a.guess_count), 40'd0);
    check("ng win",    40'(bus_a.win), 40'd0);
    check("ng lose",   40'(bus_a.lose), 40'd0);

    // Win on the final guess takes precedence over lose.
    new_game_a();
    for (int i = 0; i < MG - 1; i++) score_a("late", enc(miss[i], LW), enc("CRANE", LW));
    score_a("late_win", enc("CRANE", LW), enc("CRANE", LW));

    // Asynchronous reset mid-operation.
    new_game_a();
    score_a("pre_rst", enc("EERIE", LW), enc("CRANE", LW));
    bus_a.guess = enc("ABBEY", LW);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    step();
    step();
    step();
    #1;
    reset = 1'b1;
    #1;
    check("arst busy",   40'(bus_a.busy), 40'd0);
    check("arst colors", 40'(bus_a.colors), 40'd0);
    check("arst count",  40'(bus_a.guess_count), 40'd0);
    check("arst done",   40'(bus_a.done), 40'd0);
    step();
    reset = 1'b0;
    ma_count = 0; ma_win = 0; ma_lose = 0;
    watch_a(10, nd, nb);
    check("arst no_done", 40'(nd), 40'd0);
    check("arst no_busy", 40'(nb), 40'd0);

    // new_game mid-operation.
    score_a("pre_ng", enc("EERIE", LW), enc("CRANE", LW));
    bus_a.guess = enc("ABBEY", LW);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    step();
    step();
    bus_a.new_game = 1'b1;
    step();
    bus_a.new_game = 1'b0;
    ma_count = 0; ma_win = 0; ma_lose = 0;
    check("ngab busy",   40'(bus_a.busy), 40'd0);
    check("ngab colors", 40'(bus_a.colors), 40'd0);
    check("ngab count",  40'(bus_a.guess_count), 40'd0);
    watch_a(10, nd, nb);
    check("ngab no_done", 40'(nd), 40'd0);

    // start and new_game together: start is dropped.
    bus_a.start = 1'b1;
    bus_a.new_game = 1'b1;
    step();
    bus_a.start = 1'b0;
    bus_a.new_game = 1'b0;
    watch_a(5, nd, nb);
    check("same_cycle busy", 40'(nb), 40'd0);
    check("same_cycle done", 40'(nd), 40'd0);

    // start held for 20 cycles: busy cycles ignore it.
    bus_a.guess  = enc("ZZZZZ", LW);
    bus_a.answer = enc("CRANE", LW);
    bus_a.start  = 1'b1;
    watch_a(20, nd, nb);
    bus_a.start = 1'b0;
    check("held done_pulses", 40'(nd), 40'd2);
    check("held count", 40'(bus_a.guess_count), 40'd2);
    new_game_a();

    // Guess changed while scoring is in progress.
    bus_a.guess  = enc("EERIE", LW);
    bus_a.answer = enc("CRANE", LW);
    bus_a.start  = 1'b1;
    step();
    bus_a.start = 1'b0;
    step();
    step();
    step();
    bus_a.guess  = enc("CRANE", LW);
    bus_a.answer = enc("ZZZZZ", LW);
    lat = 3;
    while (!bus_a.done && lat < 20) begin
      step();
      lat++;
    end
    check("midchange latency", 40'(lat), 40'd7);
    check("midchange colors", 40'(bus_a.colors),
          40'(model_colors(enc("EERIE", LW), enc("CRANE", LW), WL, LW)));
    check("midchange win", 40'(bus_a.win), 40'd0);

    // Random games on the default instance.
    ans = '0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0 || ma_win || ma_lose) begin
        new_game_a();
        ans = rand_word(WL, LW);
      end
      g = ($urandom_range(0, 4) == 0) ? ans : rand_word(WL, LW);
      score_a("rand_a", g, ans);
    end

    // Narrow instance: table vectors then random games.
    for (int i = 0; i < 3; i++) begin
      new_game_b();
      score_b(vb[i].name, enc(vb[i].g, LW4), enc(vb[i].a, LW4));
      check({vb[i].name, " table"}, 40'(bus_b.colors), 40'(vb[i].exp));
    end
    for (int k = 0; k < 30; k++) begin
      if (k == 0 || mb_win || mb_lose) begin
        new_game_b();
        ans = rand_word(WL4, LW4);
      end
      g = ($urandom_range(0, 4) == 0) ? ans : rand_word(WL4, LW4);
      score_b("rand_b", g, ans);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
